// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-queue types: instruction word, PC, branch history and the queue entry.
package falco_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] raw_instruction_t;

    localparam int BHSR_W = 8;
    typedef logic [BHSR_W-1:0] BHSR_t;

    typedef struct packed {
        raw_instruction_t raw;
        pc_t              pc;
        BHSR_t            BHSR;
    } fetchq_entry_t;

    localparam int FETCHQ_DEPTH = 8;

    // Statistics counters hold at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// IF->queue->ID bundle. master = IF/ID side (bench), slave = the queue.
interface if_fetch_queue_if
    import falco_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH
);
    logic                     flush;
    logic                     in_instr0_valid;
    logic                     in_instr1_valid;
    raw_instruction_t         in_raw_instr0;
    raw_instruction_t         in_raw_instr1;
    pc_t                      in_instr0_pc;
    pc_t                      in_instr1_pc;
    BHSR_t                    in_instr0_BHSR;
    BHSR_t                    in_instr1_BHSR;
    logic                     in_ready;

    logic                     out_instr0_valid;
    logic                     out_instr1_valid;
    raw_instruction_t         out_raw_instr0;
    raw_instruction_t         out_raw_instr1;
    pc_t                      out_instr0_pc;
    pc_t                      out_instr1_pc;
    BHSR_t                    out_instr0_BHSR;
    BHSR_t                    out_instr1_BHSR;
    logic [1:0]               deq_cnt;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, in_instr0_valid, in_instr1_valid, in_raw_instr0, in_raw_instr1,
               in_instr0_pc, in_instr1_pc, in_instr0_BHSR, in_instr1_BHSR, deq_cnt,
        input  in_ready, out_instr0_valid, out_instr1_valid, out_raw_instr0, out_raw_instr1,
               out_instr0_pc, out_instr1_pc, out_instr0_BHSR, out_instr1_BHSR, count
    );

    modport slave (
        input  flush, in_instr0_valid, in_instr1_valid, in_raw_instr0, in_raw_instr1,
               in_instr0_pc, in_instr1_pc, in_instr0_BHSR, in_instr1_BHSR, deq_cnt,
        output in_ready, out_instr0_valid, out_instr1_valid, out_raw_instr0, out_raw_instr1,
               out_instr0_pc, out_instr1_pc, out_instr0_BHSR, out_instr1_BHSR, count
    );

endinterface

// File: rtl/if_fetch_queue_storage.sv
// Entry array for the fetch queue: 2 write ports, 2 asynchronous read ports, no reset.
module fetchq_storage
    import falco_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic [1:0]               we,
    input  logic [1:0][AW-1:0]       wa,
    input  fetchq_entry_t [1:0]      wd,
    input  logic [1:0][AW-1:0]       ra,
    output fetchq_entry_t [1:0]      rd
);

    fetchq_entry_t mem [DEPTH];

    // The two write addresses are always consecutive, so the ports never collide.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (we[p]) mem[wa[p]] <= wd[p];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign rd[p] = mem[ra[p]];
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Two-wide IF->ID instruction queue with compaction, flush and count-based full/empty.
// Optional statistics outputs enabled by defining FALCO_FETCHQ_STATS_EN.
module if_fetch_queue
    import falco_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_queue_if.slave    fq
`ifdef FALCO_FETCHQ_STATS_EN
    ,
    output logic [31:0]        stat_full_cycles,
    output logic [31:0]        stat_flushes
`endif
);

    // DEPTH must be a power of two >= 4 so pointers wrap by plain truncation.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [CW-1:0]          cnt;

    logic                   ready;
    logic                   enq_ok;
    logic [1:0]             n_enq;
    logic [1:0]             deq_req;
    logic [1:0]             n_deq;

    logic [1:0]             we;
    logic [1:0][AW-1:0]     wa;
    fetchq_entry_t [1:0]    wd;
    logic [1:0][AW-1:0]     ra;
    fetchq_entry_t [1:0]    rd;
    fetchq_entry_t          slot0;
    fetchq_entry_t          slot1;

    // No credit for a same-cycle dequeue: ready is a pure function of registered count.
    assign ready   = (cnt <= CW'(DEPTH - 2));
    assign enq_ok  = ready & ~fq.flush;
    assign n_enq   = enq_ok ? ({1'b0, fq.in_instr0_valid} + {1'b0, fq.in_instr1_valid}) : 2'd0;
    assign deq_req = (fq.deq_cnt == 2'd3) ? 2'd2 : fq.deq_cnt;
    assign n_deq   = (CW'(deq_req) > cnt) ? cnt[1:0] : deq_req;

    assign slot0 = '{raw: fq.in_raw_instr0, pc: fq.in_instr0_pc, BHSR: fq.in_instr0_BHSR};
    assign slot1 = '{raw: fq.in_raw_instr1, pc: fq.in_instr1_pc, BHSR: fq.in_instr1_BHSR};

    // Compaction: port 0 takes the oldest valid slot, port 1 only when both are valid.
    assign we[0] = enq_ok & (fq.in_instr0_valid | fq.in_instr1_valid);
    assign we[1] = enq_ok & fq.in_instr0_valid & fq.in_instr1_valid;
    assign wd[0] = fq.in_instr0_valid ? slot0 : slot1;
    assign wd[1] = slot1;
    assign wa[0] = wr_ptr;
    assign wa[1] = wr_ptr + AW'(1);
    assign ra[0] = rd_ptr;
    assign ra[1] = rd_ptr + AW'(1);

    fetchq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk (clk),
        .we  (we),
        .wa  (wa),
        .wd  (wd),
        .ra  (ra),
        .rd  (rd)
    );

    always_ff @(posedge clk) begin
        if (rst || fq.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(n_deq);
            wr_ptr <= wr_ptr + AW'(n_enq);
            cnt    <= cnt + CW'(n_enq) - CW'(n_deq);
        end
    end

    assign fq.in_ready         = ready;
    assign fq.count            = cnt;
    assign fq.out_instr0_valid = (cnt >= CW'(1));
    assign fq.out_instr1_valid = (cnt >= CW'(2));
    assign fq.out_raw_instr0   = rd[0].raw;
    assign fq.out_raw_instr1   = rd[1].raw;
    assign fq.out_instr0_pc    = rd[0].pc;
    assign fq.out_instr1_pc    = rd[1].pc;
    assign fq.out_instr0_BHSR  = rd[0].BHSR;
    assign fq.out_instr1_BHSR  = rd[1].BHSR;

`ifdef FALCO_FETCHQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_full_cycles <= '0;
            stat_flushes     <= '0;
        end else begin
            if (!ready)   stat_full_cycles <= sat_inc32(stat_full_cycles);
            if (fq.flush) stat_flushes     <= sat_inc32(stat_flushes);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a PC scoreboard of queued entries.
module tb_if_fetch_queue;
    import falco_pkg::*;

    localparam int DEPTH = FETCHQ_DEPTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.DEPTH(DEPTH)) fq ();

`ifdef FALCO_FETCHQ_STATS_EN
    logic [31:0] stat_full_cycles;
    logic [31:0] stat_flushes;
    int          m_full;
    int          m_flush;
`endif

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq)
`ifdef FALCO_FETCHQ_STATS_EN
        ,
        .stat_full_cycles (stat_full_cycles),
        .stat_flushes     (stat_flushes)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    logic [31:0] next_pc  = 32'h0;

    function automatic logic [31:0] mk_raw(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    function automatic logic [31:0] mk_bhsr(input logic [31:0] pc);
        return {24'h0, pc[9:2] ^ 8'h3C};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the scoreboard; called between edges.
    task automatic check_outs(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".count"},    32'(fq.count), 32'(n));
        chk({tag, ".in_ready"}, 32'(fq.in_ready), 32'((DEPTH - n) >= 2));
        chk({tag, ".v0"},       32'(fq.out_instr0_valid), 32'(n >= 1));
        chk({tag, ".v1"},       32'(fq.out_instr1_valid), 32'(n >= 2));
        if (n >= 1) begin
            chk({tag, ".pc0"},   fq.out_instr0_pc, sb[0]);
            chk({tag, ".raw0"},  fq.out_raw_instr0, mk_raw(sb[0]));
            chk({tag, ".bhsr0"}, 32'(fq.out_instr0_BHSR), mk_bhsr(sb[0]));
        end
        if (n >= 2) begin
            chk({tag, ".pc1"},   fq.out_instr1_pc, sb[1]);
            chk({tag, ".raw1"},  fq.out_raw_instr1, mk_raw(sb[1]));
            chk({tag, ".bhsr1"}, 32'(fq.out_instr1_BHSR), mk_bhsr(sb[1]));
        end
    endtask

    // One cycle: check outputs, drive inputs, take the edge, advance the model.
    task automatic step(input logic v0, input logic v1, input int deq,
                        input logic fl, input logic r, input string tag);
        logic        rdy;
        logic [31:0] p0, p1;
        int          d;
        check_outs(tag);
        rdy = (DEPTH - sb.size()) >= 2;
        p0  = next_pc;
        p1  = v0 ? next_pc + 32'd4 : next_pc;
        fq.in_instr0_valid = v0;
        fq.in_instr1_valid = v1;
        fq.in_instr0_pc    = p0;
        fq.in_instr1_pc    = p1;
        fq.in_raw_instr0   = mk_raw(p0);
        fq.in_raw_instr1   = mk_raw(p1);
        fq.in_instr0_BHSR  = BHSR_t'(mk_bhsr(p0));
        fq.in_instr1_BHSR  = BHSR_t'(mk_bhsr(p1));
        fq.deq_cnt         = 2'(deq);
        fq.flush           = fl;
        rst                = r;
        @(posedge clk);
`ifdef FALCO_FETCHQ_STATS_EN
        if (r) begin
            m_full  = 0;
            m_flush = 0;
        end else begin
            if (!rdy) m_full++;
            if (fl)   m_flush++;
        end
`endif
        if (r || fl) begin
            sb.delete();
        end else begin
            d = (deq > 2) ? 2 : deq;
            if (d > sb.size()) d = sb.size();
            repeat (d) void'(sb.pop_front());
            if (rdy) begin
                if (v0) sb.push_back(p0);
                if (v1) sb.push_back(p1);
                next_pc = next_pc + 32'(4 * (int'(v0) + int'(v1)));
            end
        end
        @(negedge clk);
        fq.in_instr0_valid = 1'b0;
        fq.in_instr1_valid = 1'b0;
        fq.deq_cnt         = 2'd0;
        fq.flush           = 1'b0;
        rst                = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        fq.flush = 1'b0;
        fq.in_instr0_valid = 1'b0;
        fq.in_instr1_valid = 1'b0;
        fq.in_raw_instr0 = '0;
        fq.in_raw_instr1 = '0;
        fq.in_instr0_pc = '0;
        fq.in_instr1_pc = '0;
        fq.in_instr0_BHSR = '0;
        fq.in_instr1_BHSR = '0;
        fq.deq_cnt = 2'd0;
`ifdef FALCO_FETCHQ_STATS_EN
        m_full  = 0;
        m_flush = 0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outs("reset");

        // Pair into empty queue, then drain it.
        step(1, 1, 0, 0, 0, "enq2");
        chk("enq2.pc0_abs", fq.out_instr0_pc, 32'h0);
        chk("enq2.pc1_abs", fq.out_instr1_pc, 32'h4);
        step(0, 0, 2, 0, 0, "deq2");

        // Slot1 alone lands at the head.
        step(0, 1, 0, 0, 0, "slot1_only");
        chk("slot1_only.pc0_abs", fq.out_instr0_pc, 32'h8);
        step(0, 0, 1, 0, 0, "deq1");

        // Fill to DEPTH-1: offered pair must be ignored, no same-cycle dequeue credit.
        step(1, 1, 0, 0, 0, "fill_a");
        step(1, 1, 0, 0, 0, "fill_b");
        step(1, 1, 0, 0, 0, "fill_c");
        step(1, 0, 0, 0, 0, "fill_d");
        chk("full.in_ready_abs", 32'(fq.in_ready), 32'd0);
        step(1, 1, 0, 0, 0, "full_offer");
        step(0, 0, 2, 0, 0, "full_deq");
        chk("after_deq.in_ready_abs", 32'(fq.in_ready), 32'd1);

        // Steady state streaming across pointer wrap.
        for (int i = 0; i < 20; i++) step(1, 1, 2, 0, 0, "stream");
        chk("stream.count_abs", 32'(fq.count), 32'd5);

        // Flush wins over same-cycle enqueue and dequeue.
        step(1, 1, 2, 1, 0, "flush");
        chk("flush.v0_abs", 32'(fq.out_instr0_valid), 32'd0);

        // Over-dequeue clamps to count; deq_cnt=3 acts as 2.
        step(1, 0, 0, 0, 0, "one");
        step(0, 0, 2, 0, 0, "underflow");
        chk("underflow.count_abs", 32'(fq.count), 32'd0);
        step(1, 1, 0, 0, 0, "three_a");
        step(1, 0, 0, 0, 0, "three_b");
        step(0, 0, 3, 0, 0, "deq3");
        chk("deq3.count_abs", 32'(fq.count), 32'd1);

        // Reset mid-stream with count=6.
        step(1, 1, 0, 0, 0, "six_a");
        step(1, 0, 0, 0, 0, "six_b");
        step(1, 1, 0, 0, 0, "six_c");
        chk("six.count_abs", 32'(fq.count), 32'd6);
        step(1, 1, 1, 1, 1, "rst_mid");
        chk("rst_mid.in_ready_abs", 32'(fq.in_ready), 32'd1);
        check_outs("final");

`ifdef FALCO_FETCHQ_STATS_EN
        chk("stat_full_cycles", stat_full_cycles, 32'(m_full));
        chk("stat_flushes",     stat_flushes,     32'(m_flush));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 8: queue entries; power of two, minimum 4.
REQ-002 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all queued instructions (redirect or exception).
- in_instr0_valid / in_instr1_valid  in  1 each  IF slot valid.
- in_raw_instr0 / in_raw_instr1  in  raw_instruction_t (32)  fetched words.
- in_instr0_pc / in_instr1_pc  in  pc_t (32)  slot PCs.
- in_instr0_BHSR / in_instr1_BHSR  in  BHSR_t  branch history per slot.
- in_ready  out  1  at least 2 free entries.
- out_instr0_valid / out_instr1_valid  out  1 each  head and head+1 present.
- out_raw_instr0/1, out_instr0_pc/1, out_instr0_BHSR/1  out  as inputs  head and head+1 contents toward ID.
- deq_cnt  in  2  instructions consumed by ID this cycle (0..2).
- count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-003 Enqueue SHALL occur only when in_ready=1 and flush=0; offered slots with in_ready=0 SHALL be ignored, and IF must hold them.
REQ-004 Valid slots SHALL be compacted in program order, slot0 then slot1; in_instr1_valid alone SHALL write one entry.
REQ-005 in_ready SHALL be (DEPTH - count) >= 2, computed from registered count only, with no credit for the same-cycle dequeue.
REQ-006 out_instr0_valid SHALL equal count>=1 and out_instr1_valid SHALL equal count>=2; data SHALL come from the head and head+1 modulo DEPTH.
REQ-007 The effective dequeue SHALL be min(deq_cnt, count); deq_cnt=3 SHALL be treated as 2.
REQ-008 Latency SHALL be one cycle: an entry enqueued at edge N becomes visible on outputs after edge N, with no combinational input-to-output bypass.
REQ-009 Simultaneous enqueue and dequeue SHALL update count = count + enq - deq in one cycle.
REQ-010 Read and write pointers SHALL wrap modulo DEPTH; full (count=DEPTH) and empty (count=0) SHALL be distinguished by count, not by pointer equality.
REQ-011 flush=1 SHALL set both pointers and count to 0 at the next edge, overriding any same-cycle enqueue and dequeue.
REQ-012 Output data SHALL be don't-care while the matching valid is 0; valids SHALL never be X after reset.

Reset
REQ-013 rst=1 SHALL clear pointers and count, and drive in_ready=1 and out_instr0_valid=out_instr1_valid=0 from the next edge.
REQ-014 rst SHALL take priority over flush, enqueue and dequeue.
REQ-015 Storage contents SHALL NOT require reset.

Configuration
REQ-016 With FALCO_FETCHQ_STATS_EN defined, the block SHALL add 32-bit saturating outputs stat_full_cycles (cycles with in_ready=0) and stat_flushes (cycles with flush=1), both cleared by rst.
REQ-017 Without FALCO_FETCHQ_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-018 Falco_pkg SHALL hold pc_t, raw_instruction_t and BHSR_t, a new fetchq_entry_t struct {raw, pc, BHSR}, and the constant FETCHQ_DEPTH=8.
REQ-019 Entry storage SHALL be a sub-module fetchq_storage: DEPTH x fetchq_entry_t, 2 write ports and 2 read ports; pointer and count logic SHALL stay in if_fetch_queue.

Verification
REQ-020 Reset then enqueue 2 (pc 0x0, 0x4) -> next cycle out valids 1/1, PCs 0x0/0x4, count=2.
REQ-021 in_instr1_valid only (pc 0x8) into empty queue -> out_instr0_pc=0x8, out_instr1_valid=0, count=1.
REQ-022 Fill to count=7 with DEPTH=8 -> in_ready=0; offered pair ignored; deq_cnt=2 -> in_ready=1 one cycle later.
REQ-023 20 cycles of enqueue 2 / dequeue 2 -> pointer wrap with PCs strictly sequential (+4), count constant.
REQ-024 count=5 with flush plus enqueue plus deq_cnt=2 same cycle -> count=0, both valids 0 next cycle.
REQ-025 count=1 with deq_cnt=2 -> count=0, no underflow; rst mid-stream with count=6 -> count=0, in_ready=1.
